// File: rtl/sync_req_queue.sv
// sync_req_queue
//   Collects single-cycle event requests into a saturating pending counter and
//   drains them one at a time into a downstream sync-with-ack stage. Each
//   transfer is a one-cycle a_vld_out pulse. The next transfer waits until the
//   downstream stage has dropped a_rdy_in and raised it again.
//
// Ports
//   clk_a        : sole clock, all state updates on its rising edge
//   a_reset_in   : asynchronous active-low reset
//   a_evt_in     : one event requested per rising edge at which it is high
//   a_rdy_in     : downstream synchronizer idle indication
//   a_clr_ovf_in : clears the sticky overflow flag
//   a_vld_out    : registered single-cycle transfer pulse
//   a_pend_out   : current pending-event count (CNT_W bits)
//   a_ovf_out    : sticky flag, set when an event is dropped
//   a_busy_out   : high whenever the handshake FSM is not in IDLE
module sync_req_queue #(
  parameter int CNT_W = 4
) (
  input  logic             clk_a,
  input  logic             a_reset_in,
  input  logic             a_evt_in,
  input  logic             a_rdy_in,
  input  logic             a_clr_ovf_in,
  output logic             a_vld_out,
  output logic [CNT_W-1:0] a_pend_out,
  output logic             a_ovf_out,
  output logic             a_busy_out
);

  typedef enum logic [1:0] {
    IDLE,
    SENT,
    BUSY
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] pend;
  logic             dec;
  logic             drop;

  // A transfer is launched only from IDLE with something pending and the
  // downstream stage idle; that same edge consumes one pending event.
  always_comb begin
    dec  = 1'b0;
    drop = 1'b0;
    dec  = (state == IDLE) && (pend != '0) && a_rdy_in;
    // An event is lost only when the counter is full and nothing drains.
    drop = a_evt_in && !dec && (pend == PEND_MAX);
  end

  always_ff @(posedge clk_a or negedge a_reset_in) begin
    if (!a_reset_in) begin
      state     <= IDLE;
      pend      <= '0;
      a_vld_out <= 1'b0;
      a_ovf_out <= 1'b0;
    end else begin
      a_vld_out <= dec;

      case (state)
        IDLE:    if (dec)       state <= SENT;
        SENT:    if (!a_rdy_in) state <= BUSY;
        BUSY:    if (a_rdy_in)  state <= IDLE;
        default:                state <= IDLE;
      endcase

      // Event plus decrement on the same edge cancel out.
      case ({a_evt_in, dec})
        2'b10:   if (pend != PEND_MAX) pend <= pend + PEND_ONE;
        2'b01:   pend <= pend - PEND_ONE;
        default: pend <= pend;
      endcase

      // Overflow has priority over a clear on the same edge.
      if (drop)              a_ovf_out <= 1'b1;
      else if (a_clr_ovf_in) a_ovf_out <= 1'b0;
    end
  end

  assign a_pend_out = pend;
  assign a_busy_out = (state != IDLE);

endmodule

// File: tb/tb_sync_req_queue.sv
module tb_sync_req_queue;

  localparam int CNT_W = 4;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic             clk_a = 1'b0;
  logic             clk_b = 1'b0;
  logic             a_reset_in;
  logic             a_evt_in;
  logic             rdy_drv;
  logic             a_rdy_in;
  logic             a_clr_ovf_in;
  logic             a_vld_out;
  logic [CNT_W-1:0] a_pend_out;
  logic             a_ovf_out;
  logic             a_busy_out;
  logic             loop_mode;

  always #7 clk_a = ~clk_a;
  always #5 clk_b = ~clk_b;

  sync_req_queue #(.CNT_W(CNT_W)) dut (
    .clk_a        (clk_a),
    .a_reset_in   (a_reset_in),
    .a_evt_in     (a_evt_in),
    .a_rdy_in     (a_rdy_in),
    .a_clr_ovf_in (a_clr_ovf_in),
    .a_vld_out    (a_vld_out),
    .a_pend_out   (a_pend_out),
    .a_ovf_out    (a_ovf_out),
    .a_busy_out   (a_busy_out)
  );

  // Behavioural downstream sync-with-ack stage: toggle request into clk_b,
  // toggle acknowledge back into clk_a; idle when both toggles agree.
  logic ds_tog, ack_s1, ack_s2, b_s1, b_s2, b_s3, b_vld, rdy_ds;
  int   b_cnt = 0;

  always @(posedge clk_a or negedge a_reset_in) begin
    if (!a_reset_in) begin
      ds_tog <= 1'b0; ack_s1 <= 1'b0; ack_s2 <= 1'b0;
    end else begin
      if (a_vld_out) ds_tog <= ~ds_tog;
      ack_s1 <= b_s3;
      ack_s2 <= ack_s1;
    end
  end

  always @(posedge clk_b or negedge a_reset_in) begin
    if (!a_reset_in) begin
      b_s1 <= 1'b0; b_s2 <= 1'b0; b_s3 <= 1'b0;
    end else begin
      b_s1 <= ds_tog; b_s2 <= b_s1; b_s3 <= b_s2;
    end
  end

  assign b_vld    = b_s2 ^ b_s3;
  assign rdy_ds   = (ds_tog == ack_s2);
  assign a_rdy_in = loop_mode ? rdy_ds : rdy_drv;

  always @(posedge clk_b) if (b_vld) b_cnt <= b_cnt + 1;

  // ---------------------------------------------------------------- checking
  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int vld, input int pend,
                            input int ovf, input int busy);
    check({tag, ".vld"},  int'(a_vld_out),  vld);
    check({tag, ".pend"}, int'(a_pend_out), pend);
    check({tag, ".ovf"},  int'(a_ovf_out),  ovf);
    check({tag, ".busy"}, int'(a_busy_out), busy);
  endtask

  // Reference model: count, sticky flag, and the two handshake waits
  // (transfer issued -> wait for ready low -> wait for ready high).
  int m_pend;
  int m_ovf;
  int m_vld;
  bit wait_drop;
  bit wait_rise;

  task automatic model_reset();
    m_pend = 0; m_ovf = 0; m_vld = 0; wait_drop = 0; wait_rise = 0;
  endtask

  task automatic model_step(input bit evt, input bit rdy, input bit clr);
    bit issue;
    int nxt;
    issue = !wait_drop && !wait_rise && (m_pend > 0) && rdy;
    if (issue)                  wait_drop = 1;
    else if (wait_drop && !rdy) begin wait_drop = 0; wait_rise = 1; end
    else if (wait_rise && rdy)  wait_rise = 0;
    m_vld = issue ? 1 : 0;
    nxt = m_pend - (issue ? 1 : 0) + (evt ? 1 : 0);
    if (nxt > MAX) begin nxt = MAX; m_ovf = 1; end
    else if (clr) m_ovf = 0;
    m_pend = nxt;
  endtask

  // Drive inputs at posedge+1, sample at the following posedge+1.
  task automatic drive_edge(input bit evt, input bit rdy, input bit clr);
    a_evt_in = evt; rdy_drv = rdy; a_clr_ovf_in = clr;
    @(posedge clk_a);
    #1;
  endtask

  task automatic model_cycle(input string tag, input bit evt, input bit rdy, input bit clr);
    drive_edge(evt, rdy, clr);
    model_step(evt, rdy, clr);
    check_outs(tag, m_vld, m_pend, m_ovf, (wait_drop || wait_rise) ? 1 : 0);
  endtask

  task automatic reset_dut();
    a_reset_in = 1'b0;
    a_evt_in = 1'b1; rdy_drv = 1'b1; a_clr_ovf_in = 1'b0;
    repeat (2) @(posedge clk_a);
    #1;
    a_reset_in = 1'b1;
    a_evt_in = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit evt, rdy, clr;
    int vld, pend, ovf, busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit evt, input bit rdy, input bit clr,
                     input int vld, input int pend, input int ovf, input int busy);
    vec_t v;
    v.evt = evt; v.rdy = rdy; v.clr = clr;
    v.vld = vld; v.pend = pend; v.ovf = ovf; v.busy = busy;
    tbl.push_back(v);
  endtask

  initial begin
    int start_cnt;
    int budget;

    // Single event, then idle handshake.
    add(1, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0);
    // Burst of three with ready low, then three ack rounds.
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 2, 0, 0);
    add(1, 0, 0, 0, 3, 0, 0);
    for (int unsigned k = 0; k < 3; k++) begin
      add(0, 1, 0, 1, 2 - int'(k), 0, 1);
      add(0, 0, 0, 0, 2 - int'(k), 0, 1);
      add(0, 1, 0, 0, 2 - int'(k), 0, 0);
    end
    // Saturation: sixteen events into a fifteen-deep counter.
    for (int unsigned k = 1; k <= 16; k++)
      add(1, 0, 0, 0, (k > 15) ? 15 : int'(k), (k > 15) ? 1 : 0, 0);
    add(0, 0, 1, 0, 15, 0, 0);
    // Full counter: event and decrement together, then overflow beats clear.
    add(1, 1, 0, 1, 15, 0, 1);
    add(1, 0, 1, 0, 15, 1, 1);
    add(0, 1, 0, 0, 15, 1, 0);
    add(0, 0, 1, 0, 15, 0, 0);

    loop_mode = 1'b0;
    a_reset_in = 1'b1; a_evt_in = 1'b0; rdy_drv = 1'b0; a_clr_ovf_in = 1'b0;
    #2;
    reset_dut();
    check_outs("reset", 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive_edge(tbl[i].evt, tbl[i].rdy, tbl[i].clr);
      check_outs($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].pend, tbl[i].ovf, tbl[i].busy);
    end

    // Reset while BUSY with two pending.
    reset_dut();
    check_outs("rst2", 0, 0, 0, 0);
    repeat (3) model_cycle("fill", 1, 0, 0);
    model_cycle("issue", 0, 1, 0);
    model_cycle("tobusy", 0, 0, 0);
    check("busy_pend2", int'(a_pend_out), 2);
    #3;
    a_reset_in = 1'b0;
    a_evt_in = 1'b1;
    #1;
    check_outs("async_rst", 0, 0, 0, 0);
    repeat (3) @(posedge clk_a);
    #1;
    a_reset_in = 1'b1;
    a_evt_in = 1'b0;
    model_reset();
    repeat (6) model_cycle("post_rst", 0, 1, 0);

    // Randomized run against the reference model.
    reset_dut();
    for (int unsigned n = 0; n < 800; n++) begin
      bit evt, rdy, clr;
      evt = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < ((n < 400) ? 30 : 70));
      clr = ($urandom_range(0, 99) < 5);
      model_cycle("rand", evt, rdy, clr);
    end

    // Closed loop with the downstream stage.
    reset_dut();
    loop_mode = 1'b1;
    start_cnt = b_cnt;
    repeat (16) drive_edge(1, 1, 0);
    a_evt_in = 1'b0;
    budget = 0;
    while (!((b_cnt - start_cnt) == 16 && !a_busy_out && a_pend_out == '0) && budget < 3000) begin
      @(posedge clk_a);
      #1;
      budget++;
    end
    check("loop_timeout", (budget < 3000) ? 1 : 0, 1);
    repeat (50) @(posedge clk_a);
    #1;
    check("loop_bpulses", b_cnt - start_cnt, 16);
    check("loop_ovf", int'(a_ovf_out), 0);
    check("loop_pend", int'(a_pend_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Transfer pulse must never last two cycles.
  logic vld_q = 1'b0;
  always @(posedge clk_a) begin
    if (vld_q && a_vld_out && a_reset_in) begin
      miscompares++;
      $display("FAIL vld_double: got 1, expected 0 (t=%0t)", $time);
    end
    vld_q <= a_vld_out;
  end

endmodule

// File: doc/sync_req_queue.md
SYNC_REQ_QUEUE -- requirements
Module: sync_req_queue

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the width of the pending-event counter (capacity 2^CNT_W-1).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset.
REQ-003 Port clk_a, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port a_reset_in, input, 1: asynchronous, active-low reset.
REQ-005 Port a_evt_in, input, 1: one event is requested for every rising clk_a edge at which this input is high.
REQ-006 Port a_rdy_in, input, 1: synchronizer-idle indication returned by the downstream sync-with-ack stage.
REQ-007 Port a_vld_out, output, 1: single-cycle transfer pulse driven into the downstream sync-with-ack stage's a_vld_in.
REQ-008 Port a_clr_ovf_in, input, 1: clears the sticky overflow flag.
REQ-009 Port a_pend_out, output, CNT_W: current pending-event count.
REQ-010 Port a_ovf_out, output, 1: sticky flag set when an event is dropped.
REQ-011 Port a_busy_out, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SENT and BUSY.
REQ-013 In IDLE, when pend != 0 and a_rdy_in = 1, the block SHALL on that edge set a_vld_out to 1, decrement pend by one, and go to SENT.
REQ-014 a_vld_out SHALL be a register and SHALL be high for exactly one clk_a cycle per transfer; it is never high in two consecutive cycles.
REQ-015 In SENT, the FSM SHALL stay until a_rdy_in = 0 is sampled, then go to BUSY.
REQ-016 In BUSY, the FSM SHALL stay until a_rdy_in = 1 is sampled, then go to IDLE.
REQ-017 From IDLE, the next transfer SHALL be issued no earlier than the edge after the FSM re-enters IDLE.
REQ-018 In IDLE with pend = 0, or with a_rdy_in = 0, the FSM SHALL not issue a transfer.
REQ-019 On a_evt_in = 1 without a decrement on the same edge, pend SHALL increment by one.
REQ-020 On a_evt_in = 1 with a decrement on the same edge, pend SHALL be unchanged.
REQ-021 When pend = 2^CNT_W-1, a_evt_in = 1 and there is no decrement on that edge, pend SHALL hold (saturate, no wrap) and a_ovf_out SHALL be set to 1.
REQ-022 When pend is at maximum, a_evt_in = 1 and a decrement occurs on the same edge, pend SHALL hold and a_ovf_out SHALL not be set.
REQ-023 a_ovf_out SHALL remain set until an edge with a_clr_ovf_in = 1; if an overflow and a clear occur on the same edge, the overflow SHALL win and a_ovf_out stays 1.
REQ-024 a_pend_out SHALL equal the registered pend value.
REQ-025 a_busy_out SHALL be combinationally (state != IDLE).
REQ-026 Arithmetic on pend SHALL be unsigned CNT_W-bit, never wrapping in either direction.

Reset
REQ-027 While a_reset_in = 0, asynchronously: state SHALL be IDLE, pend = 0, a_vld_out = 0, a_ovf_out = 0, a_busy_out = 0.
REQ-028 a_evt_in pulses present while a_reset_in = 0 SHALL be discarded.
REQ-029 A reset asserted mid-transfer (in SENT or BUSY) SHALL abort the transfer; after release, the FSM SHALL resume from IDLE with pend = 0.
REQ-030 The first transfer after reset release SHALL require a new a_evt_in and a_rdy_in = 1.

Verification
REQ-031 Single event: reset release; a_rdy_in = 1; one a_evt_in pulse -> pend goes to 1, then a_vld_out is high one cycle, pend goes to 0 and state is SENT; drive a_rdy_in 0 then 1 -> IDLE.
REQ-032 Burst: 3 consecutive a_evt_in cycles with a_rdy_in held 0 -> pend = 3, no a_vld_out; toggle a_rdy_in through three ack cycles -> exactly 3 a_vld_out pulses, pend = 0.
REQ-033 Saturation (CNT_W = 4): 16 events with a_rdy_in = 0 -> pend = 15 and a_ovf_out = 1; a_clr_ovf_in pulse -> a_ovf_out = 0 while pend stays 15.
REQ-034 Simultaneous events: with pend = 15 in IDLE and a_rdy_in = 1, assert a_evt_in -> pulse issued, pend stays 15, a_ovf_out stays 0; on an edge with both overflow and a_clr_ovf_in -> a_ovf_out stays 1.
REQ-035 Reset mid-operation: assert a_reset_in = 0 while in BUSY with pend = 2 -> all outputs 0 immediately; after release, no a_vld_out occurs without new events.
REQ-036 Closed loop: connect the block to the downstream sync-with-ack stage (clk_a period 14 ns, clk_b period 10 ns) and send 16 events -> exactly 16 b_vld_out pulses, a_ovf_out = 0.
